// File: rtl/mdr_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mdr_pkg
//  Purpose  : Shared types and encodings for the memory data register
//             controller: FSM state enum and access-size encodings.
//  Config   : MDR_TIMEOUT_EN adds the ST_ERR state used by the read timeout.
//  Revision : 1.0  initial release
// ============================================================================
package mdr_pkg;

  // FSM states. ST_ERR is only present when the timeout feature is built in.
`ifdef MDR_TIMEOUT_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } mdr_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } mdr_state_e;
`endif

  // Access-size encodings; 2'b11 is treated as a full word as well.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

endpackage : mdr_pkg
`default_nettype wire

// File: rtl/mdr_lane_extract.sv
`default_nettype none
// ============================================================================
//  Module   : mdr_lane_extract
//  Purpose  : Combinational sub-word lane selection with sign/zero extension.
//  Ports    : data_i    - raw memory word
//             size_i    - 00 byte, 01 half, 10/11 full word
//             sign_i    - 1 sign-extend, 0 zero-extend (sub-word only)
//             addr_lo_i - byte offset of the lane (half ignores bit 0)
//             data_o    - extracted, extended value
//  Revision : 1.0  initial release
// ============================================================================
module mdr_lane_extract
  import mdr_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int OFF_W = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic [1:0]        size_i,
  input  logic              sign_i,
  input  logic [OFF_W-1:0]  addr_lo_i,
  output logic [DATA_W-1:0] data_o
);

  logic [OFF_W-1:0]  w_half_lane;
  logic [DATA_W-1:0] w_byte_shift;
  logic [DATA_W-1:0] w_half_shift;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;

  // Halfwords are aligned: drop the low offset bit rather than straddle lanes.
  assign w_half_lane  = addr_lo_i & ~OFF_W'(1);
  assign w_byte_shift = data_i >> {addr_lo_i, 3'b000};
  assign w_half_shift = data_i >> {w_half_lane, 3'b000};
  assign w_byte       = w_byte_shift[7:0];
  assign w_half       = w_half_shift[15:0];

  always_comb begin
    data_o = data_i;
    case (size_i)
      SZ_BYTE: data_o = {{(DATA_W-8){sign_i & w_byte[7]}}, w_byte};
      SZ_HALF: data_o = {{(DATA_W-16){sign_i & w_half[15]}}, w_half};
      default: data_o = data_i;
    endcase
  end

endmodule : mdr_lane_extract
`default_nettype wire

// File: rtl/mdr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mdr_ctrl
//  Purpose  : Memory data register with bus load and sized memory read.
//  Ports    : clk        - clock, rising edge
//             clr        - asynchronous active-high reset
//             MDRin      - load strobe (sampled in IDLE only)
//             Read       - 1 memory read, 0 load from BusMuxOut
//             BusMuxOut  - bus data
//             Mdatain    - memory data, valid with mem_ready
//             mem_ready  - memory completion
//             size/sign/addr_lo - access size, extension, byte offset
//             rd_req     - read request (high while waiting)
//             MDROut     - register contents
//             busy       - transaction in progress
//             done       - one-cycle pulse after memory capture
//             err        - sticky read timeout flag
//  Config   : MDR_TIMEOUT_EN enables the WAIT_MAX read timeout and ERR state;
//             without it a read waits indefinitely and err is tied low.
//  Revision : 1.0  initial release
// ============================================================================
module mdr_ctrl
  import mdr_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int WAIT_MAX = 15,
  localparam int OFF_W   = $clog2(DATA_W / 8)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              MDRin,
  input  logic              Read,
  input  logic [DATA_W-1:0] BusMuxOut,
  input  logic [DATA_W-1:0] Mdatain,
  input  logic              mem_ready,
  input  logic [1:0]        size,
  input  logic              sign,
  input  logic [OFF_W-1:0]  addr_lo,
  output logic              rd_req,
  output logic [DATA_W-1:0] MDROut,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Elaboration-time parameter guard.
  generate
    if ((DATA_W < 16) || ((DATA_W & (DATA_W - 1)) != 0) ||
        (WAIT_MAX < 1) || (WAIT_MAX > 255)) begin : g_bad_param
      $error("mdr_ctrl: illegal DATA_W or WAIT_MAX");
    end
  endgenerate

  mdr_state_e        state_q, state_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic [1:0]        size_q, size_d;
  logic              sign_q, sign_d;
  logic [OFF_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0] w_extracted;
  logic              w_accept;
  logic              w_bus_load;
  logic              w_capture;

  assign w_bus_load = (state_q == ST_IDLE) && MDRin && !Read;
  assign w_accept   = (state_q == ST_IDLE) && MDRin && Read;
  assign w_capture  = (state_q == ST_WAIT) && mem_ready;

  // Extraction uses the controls latched at acceptance, never the live ones.
  mdr_lane_extract #(.DATA_W(DATA_W)) u_extract (
    .data_i    (Mdatain),
    .size_i    (size_q),
    .sign_i    (sign_q),
    .addr_lo_i (addr_q),
    .data_o    (w_extracted)
  );

`ifdef MDR_TIMEOUT_EN
  localparam int CNT_W = 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             w_timeout;

  // Fires on the last permitted non-ready WAIT cycle.
  assign w_timeout = (state_q == ST_WAIT) && !mem_ready &&
                     (cnt_q == CNT_W'(WAIT_MAX - 1));
`endif

  // ---------------------------------------------------------------- FSM: state register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------- FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (w_accept) state_d = ST_WAIT;
      ST_WAIT: begin
        if (mem_ready) begin
          state_d = ST_DONE;
`ifdef MDR_TIMEOUT_EN
        end else if (w_timeout) begin
          state_d = ST_ERR;
`endif
        end
      end
      ST_DONE: state_d = ST_IDLE;
`ifdef MDR_TIMEOUT_EN
      ST_ERR:  state_d = ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- FSM: outputs
  always_comb begin
    rd_req = 1'b0;
    done   = 1'b0;
    busy   = (state_q != ST_IDLE);
    case (state_q)
      ST_WAIT: rd_req = 1'b1;
      ST_DONE: done   = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_comb begin
    mdr_d  = mdr_q;
    size_d = size_q;
    sign_d = sign_q;
    addr_d = addr_q;
    if (w_bus_load) begin
      mdr_d = BusMuxOut;
    end else if (w_capture) begin
      mdr_d = w_extracted;
    end
    if (w_accept) begin
      size_d = size;
      sign_d = sign;
      addr_d = addr_lo;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      mdr_q  <= '0;
      size_q <= SZ_BYTE;
      sign_q <= 1'b0;
      addr_q <= '0;
    end else begin
      mdr_q  <= mdr_d;
      size_q <= size_d;
      sign_q <= sign_d;
      addr_q <= addr_d;
    end
  end

  assign MDROut = mdr_q;

`ifdef MDR_TIMEOUT_EN
  // Counter and sticky error; both are cleared by the next accepted read.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (w_accept) begin
      cnt_d = '0;
      err_d = 1'b0;
    end else if ((state_q == ST_WAIT) && !mem_ready) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (w_timeout) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule : mdr_ctrl
`default_nettype wire

// File: tb/tb_mdr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mdr_ctrl
//  Purpose  : Self-checking bench for mdr_ctrl: directed scenarios plus
//             randomized traffic compared every cycle against a behavioural
//             model. Build with MDR_TIMEOUT_EN to cover the timeout path.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mdr_ctrl;

  localparam int DATA_W   = 32;
  localparam int WAIT_MAX = 15;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        MDRin = 1'b0;
  logic        Read = 1'b0;
  logic [31:0] BusMuxOut = '0;
  logic [31:0] Mdatain = '0;
  logic        mem_ready = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sign = 1'b0;
  logic [1:0]  addr_lo = 2'b00;
  logic        rd_req;
  logic [31:0] MDROut;
  logic        busy;
  logic        done;
  logic        err;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  mdr_ctrl #(.DATA_W(DATA_W), .WAIT_MAX(WAIT_MAX)) dut (
    .clk       (clk),
    .clr       (clr),
    .MDRin     (MDRin),
    .Read      (Read),
    .BusMuxOut (BusMuxOut),
    .Mdatain   (Mdatain),
    .mem_ready (mem_ready),
    .size      (size),
    .sign      (sign),
    .addr_lo   (addr_lo),
    .rd_req    (rd_req),
    .MDROut    (MDROut),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model
  // phase: 0 idle, 1 waiting for memory, 2 data just captured, 3 timed out
  int          m_phase = 0;
  logic [31:0] m_mdr   = '0;
  logic        m_err   = 1'b0;
  int          m_cnt   = 0;
  logic [1:0]  m_size  = '0;
  logic        m_sign  = 1'b0;
  logic [1:0]  m_off   = '0;

  function automatic logic [31:0] model_extract(input logic [31:0] d,
                                                input logic [1:0] sz,
                                                input logic sg,
                                                input logic [1:0] off);
    int          nbits;
    int          lane;
    logic [31:0] v;
    logic [31:0] mask;
    if (sz == 2'b00) begin
      nbits = 8;  lane = int'(off);
    end else if (sz == 2'b01) begin
      nbits = 16; lane = int'(off) & 2;
    end else begin
      return d;
    end
    v    = d >> (8 * lane);
    mask = (32'h1 << nbits) - 32'h1;
    v    = v & mask;
    if (sg && v[nbits-1]) v = v | ~mask;
    return v;
  endfunction

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      m_phase <= 0;
      m_mdr   <= '0;
      m_err   <= 1'b0;
      m_cnt   <= 0;
    end else begin
      case (m_phase)
        0: begin
          if (MDRin && !Read) m_mdr <= BusMuxOut;
          if (MDRin && Read) begin
            m_size  <= size;
            m_sign  <= sign;
            m_off   <= addr_lo;
            m_cnt   <= 0;
            m_err   <= 1'b0;
            m_phase <= 1;
          end
        end
        1: begin
          if (mem_ready) begin
            m_mdr   <= model_extract(Mdatain, m_size, m_sign, m_off);
            m_phase <= 2;
          end
`ifdef MDR_TIMEOUT_EN
          else begin
            m_cnt <= m_cnt + 1;
            if (m_cnt + 1 == WAIT_MAX) begin
              m_phase <= 3;
              m_err   <= 1'b1;
            end
          end
`endif
        end
        default: m_phase <= 0;
      endcase
    end
  end

  // ---------------------------------------------------------------- checking
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("mdrout", MDROut, m_mdr);
      check("rd_req", 32'(rd_req), 32'(m_phase == 1));
      check("busy",   32'(busy),   32'(m_phase != 0));
      check("done",   32'(done),   32'(m_phase == 2));
      check("err",    32'(err),    32'(m_err));
    end
  end

  // Inputs change 1 time unit after the falling edge.
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    cyc();
    cyc();
    check("rst_mdrout", MDROut, 32'h0);
    check("rst_busy",   32'(busy), 32'h0);
    check("rst_rd_req", 32'(rd_req), 32'h0);
    clr = 1'b0;
    chk_en = 1'b1;
    cyc();

    // Bus load.
    MDRin = 1'b1; Read = 1'b0; BusMuxOut = 32'hDEADBEEF;
    cyc();
    MDRin = 1'b0;
    check("busload_mdr",    MDROut, 32'hDEADBEEF);
    check("busload_rd_req", 32'(rd_req), 32'h0);
    check("busload_busy",   32'(busy), 32'h0);

    // Signed byte read, memory ready on the fourth WAIT cycle.
    MDRin = 1'b1; Read = 1'b1; size = 2'b00; sign = 1'b1; addr_lo = 2'd2;
    cyc();
    MDRin = 1'b0;
    size = 2'b10; sign = 1'b0; addr_lo = 2'd0;   // late changes must not matter
    Mdatain = 32'h1280FF34;
    for (int i = 0; i < 4; i++) begin
      check("sbyte_rd_req", 32'(rd_req), 32'h1);
      mem_ready = (i == 3);
      cyc();
    end
    mem_ready = 1'b0;
    check("sbyte_done",   32'(done), 32'h1);
    check("sbyte_rd_off", 32'(rd_req), 32'h0);
    check("sbyte_mdr",    MDROut, 32'hFFFFFF80);
    cyc();
    check("sbyte_done_off", 32'(done), 32'h0);
    check("sbyte_idle",     32'(busy), 32'h0);

    // Unsigned half read, addr_lo=3 selects lane 2.
    MDRin = 1'b1; Read = 1'b1; size = 2'b01; sign = 1'b0; addr_lo = 2'd3;
    cyc();
    MDRin = 1'b0; Mdatain = 32'h8001ABCD; mem_ready = 1'b1;
    cyc();
    mem_ready = 1'b0;
    check("uhalf_mdr", MDROut, 32'h00008001);
    cyc();

    // Bus load attempt during WAIT is ignored.
    MDRin = 1'b1; Read = 1'b1; size = 2'b10; sign = 1'b1; addr_lo = 2'd1;
    cyc();
    Read = 1'b0; BusMuxOut = 32'h11111111;
    cyc();
    MDRin = 1'b0;
    check("wait_ignore_mdr", MDROut, 32'h00008001);
    Mdatain = 32'hCAFEF00D; mem_ready = 1'b1;
    cyc();
    mem_ready = 1'b0;
    check("word_mdr", MDROut, 32'hCAFEF00D);
    cyc();

    // Asynchronous reset in the middle of WAIT.
    MDRin = 1'b1; Read = 1'b1; size = 2'b00; sign = 1'b0; addr_lo = 2'd0;
    cyc();
    MDRin = 1'b0;
    check("midwait_rd_req", 32'(rd_req), 32'h1);
    clr = 1'b1;
    #1;
    check("clr_rd_req", 32'(rd_req), 32'h0);
    check("clr_mdr",    MDROut, 32'h0);
    check("clr_busy",   32'(busy), 32'h0);
    #1;
    clr = 1'b0;
    cyc();
    mem_ready = 1'b1; Mdatain = 32'h000000AA;
    cyc();
    mem_ready = 1'b0;
    check("post_clr_mdr",  MDROut, 32'h0);
    check("post_clr_done", 32'(done), 32'h0);

`ifdef MDR_TIMEOUT_EN
    // Timeout: mem_ready never arrives.
    MDRin = 1'b1; Read = 1'b0; BusMuxOut = 32'h5A5A1234;
    cyc();
    Read = 1'b1;
    cyc();
    MDRin = 1'b0;
    for (int i = 0; i < WAIT_MAX; i++) begin
      check("to_rd_req", 32'(rd_req), 32'h1);
      cyc();
    end
    check("to_rd_off", 32'(rd_req), 32'h0);
    check("to_err",    32'(err), 32'h1);
    check("to_mdr",    MDROut, 32'h5A5A1234);
    cyc();
    check("to_idle",   32'(busy), 32'h0);
    check("to_sticky", 32'(err), 32'h1);
    MDRin = 1'b1; Read = 1'b1;
    cyc();
    MDRin = 1'b0;
    check("to_err_clr", 32'(err), 32'h0);
    mem_ready = 1'b1;
    cyc();
    mem_ready = 1'b0;
    cyc();
`endif

    // Randomized traffic; the per-cycle compare process does the checking.
    for (int n = 0; n < 3000; n++) begin
      cyc();
      clr       = ($urandom_range(0, 96) == 0);
      MDRin     = ($urandom_range(0, 2) == 0);
      Read      = $urandom_range(0, 1) == 1;
      size      = 2'($urandom_range(0, 3));
      sign      = $urandom_range(0, 1) == 1;
      addr_lo   = 2'($urandom_range(0, 3));
      BusMuxOut = $urandom;
      Mdatain   = $urandom;
      mem_ready = ($urandom_range(0, 3) == 0);
    end
    cyc();
    clr = 1'b0;
    cyc();
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mdr_ctrl
`default_nettype wire
